// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit drain engine and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the terminal count and
// restarts from zero either on that count or on an explicit clear.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_bit_done = (r_cnt == TC);

endmodule

// File: rtl/uart_tx_drain.sv
// Drains the FWFT byte buffer onto the serial line as 8N1 (or 8N2) frames and
// counts completed frames for the debug display.
//
//   state | meaning
//   IDLE  | line high; pop the head byte when enabled and the buffer is non-empty
//   START | start bit (low)
//   DATA  | eight data bits, LSB first
//   STOP  | one or two stop bits (high); frame counted on the last cycle
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int STOP_BITS = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic [7:0]           i_rd_data,
    input  logic                 i_rd_valid,
    output logic                 o_rd_en,
    output logic                 o_serial_tx,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_sent_count
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t r_state;
    uart_tx_state_t w_state_next;

    logic [UART_DATA_BITS-1:0] r_shift;
    logic [2:0]                r_bit_idx;
    logic                      r_stop_idx;
    logic                      w_accept;
    logic                      w_frame_done;
    logic                      w_bit_done;
    logic                      w_clear;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_clear),
        .o_bit_done(w_bit_done)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable && i_rd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_done) w_state_next = DATA;
            end
            DATA: begin
                if (w_bit_done && (r_bit_idx == LAST_BIT)) w_state_next = STOP;
            end
            STOP: begin
                if (w_bit_done && (r_stop_idx == LAST_STOP)) begin
                    w_frame_done = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Holding the counter at zero through IDLE makes START begin on a fresh bit period.
    assign w_clear = (r_state == IDLE) || (w_state_next != r_state);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            o_serial_tx  <= 1'b1;
            o_rd_en      <= 1'b0;
            o_busy       <= 1'b0;
            o_sent_count <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            o_rd_en <= w_accept;
            o_busy  <= (w_state_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift     <= i_rd_data;
                        o_serial_tx <= 1'b0;
                        r_bit_idx   <= '0;
                        r_stop_idx  <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_done) o_serial_tx <= r_shift[0];
                end
                DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == LAST_BIT) begin
                            o_serial_tx <= 1'b1;
                        end else begin
                            o_serial_tx <= r_shift[1];
                            r_shift     <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                            r_bit_idx   <= r_bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        if (w_frame_done) begin
                            o_sent_count <= o_sent_count + CNT_WIDTH'(1);
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end
                end
                default: o_serial_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: emulated FWFT buffer, mid-bit line decoder and
// per-scenario checks against frame timing derived from the baud arithmetic.
module tb_uart_tx_drain;

    localparam int CPB    = 50_000_000 / 115200;
    localparam int HALF   = CPB / 2;
    localparam int PERIOD = 10 * CPB + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b0;
    logic        enable   = 1'b0;
    logic [7:0]  rd_data  = 8'h00;
    logic        rd_valid = 1'b0;
    logic        rd_en;
    logic        serial_tx;
    logic        busy;
    logic [15:0] sent_count;

    logic        rst_s = 1'b0;
    logic        en_s  = 1'b0;
    logic [7:0]  rdd_s = 8'h00;
    logic        rdv_s = 1'b0;
    logic        rd_en_s;
    logic        tx_s;
    logic        busy_s;
    logic [3:0]  cnt_s;

    uart_tx_drain u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .i_rd_data   (rd_data),
        .i_rd_valid  (rd_valid),
        .o_rd_en     (rd_en),
        .o_serial_tx (serial_tx),
        .o_busy      (busy),
        .o_sent_count(sent_count)
    );

    uart_tx_drain #(
        .CLK_FREQ (16),
        .BAUD     (4),
        .STOP_BITS(2),
        .CNT_WIDTH(4)
    ) u_small (
        .i_clk       (clk),
        .i_rst       (rst_s),
        .i_enable    (en_s),
        .i_rd_data   (rdd_s),
        .i_rd_valid  (rdv_s),
        .o_rd_en     (rd_en_s),
        .o_serial_tx (tx_s),
        .o_busy      (busy_s),
        .o_sent_count(cnt_s)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sent_model = 0;

    logic [7:0] q[$];
    logic [7:0] rx_q[$];
    int         rd_en_log[$];
    int         start_log[$];

    bit         mon_act  = 1'b0;
    int         mon_t    = 0;
    int         mon_ferr = 0;
    logic       prev_tx  = 1'b1;
    logic [9:0] mon_bits = '0;
    logic [9:0] last_bits = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model (pop on rd_en) and line decoder sampling each bit at its centre.
    always @(negedge clk) begin
        if (rd_en) begin
            rd_en_log.push_back(cyc);
            if (q.size() > 0) void'(q.pop_front());
            rd_valid = (q.size() != 0);
            rd_data  = (q.size() != 0) ? q[0] : 8'h00;
        end
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (prev_tx === 1'b1 && serial_tx === 1'b0) begin
                mon_act = 1'b1;
                mon_t   = 0;
                start_log.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t >= HALF && ((mon_t - HALF) % CPB) == 0) begin
                mon_bits = {serial_tx, mon_bits[9:1]};
                if (mon_t == HALF + 9 * CPB) begin
                    mon_act = 1'b0;
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) mon_ferr++;
                    rx_q.push_back(mon_bits[8:1]);
                    last_bits = mon_bits;
                end
            end
        end
        prev_tx = serial_tx;
    end

    task automatic push_byte(input logic [7:0] b);
        q.push_back(b);
        rd_valid = 1'b1;
        rd_data  = q[0];
    endtask

    task automatic clear_logs();
        rd_en_log.delete();
        start_log.delete();
        rx_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        push_byte(8'hA5);
        repeat (8) begin
            sample();
            total++;
            if (serial_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", serial_tx); end
            total++;
            if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
            total++;
            if (sent_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", sent_count); end
        end
        clear_logs();
        step();
        rst = 1'b0;
        sent_model = 0;
        #1;
        total++;
        if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_release_rd_en got=%b exp=0", rd_en); end
    endtask

    task automatic test_single();
        int c;
        logic [9:0] exp_bits;
        int ferr0;
        ferr0    = mon_ferr;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 5 && rd_en_log.size() == 0; i++) sample();
        total++;
        if (rd_en_log.size() == 0) begin
            bad++; $display("FAIL single_rd_en got=none exp=pulse");
            return;
        end
        c = rd_en_log[0];
        while (cyc < c + 10 * CPB - 1) sample();
        total++;
        if (busy !== 1'b1 || sent_count !== 16'd0)
            begin bad++; $display("FAIL single_last_stop got busy=%b cnt=%0d exp busy=1 cnt=0", busy, sent_count); end
        sample();
        sent_model = 1;
        total++;
        if (busy !== 1'b0 || sent_count !== 16'(sent_model) || serial_tx !== 1'b1)
            begin bad++; $display("FAIL single_end got busy=%b cnt=%0d tx=%b exp busy=0 cnt=1 tx=1", busy, sent_count, serial_tx); end
        repeat (50) sample();
        total++;
        if (rd_en_log.size() != 1) begin bad++; $display("FAIL single_rd_en_count got=%0d exp=1", rd_en_log.size()); end
        total++;
        if (start_log.size() == 0 || start_log[0] != c)
            begin bad++; $display("FAIL single_start_cycle got=%0d exp=%0d", (start_log.size() > 0) ? start_log[0] : -1, c); end
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5)
            begin bad++; $display("FAIL single_byte got_n=%0d exp=A5", rx_q.size()); end
        total++;
        if (last_bits !== exp_bits) begin bad++; $display("FAIL single_bits got=%b exp=%b", last_bits, exp_bits); end
        total++;
        if (mon_ferr != ferr0) begin bad++; $display("FAIL single_framing got=%0d exp=%0d", mon_ferr, ferr0); end
    endtask

    task automatic run_queue(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp[3];
        int ferr0;
        exp   = '{b0, b1, b2};
        ferr0 = mon_ferr;
        clear_logs();
        step();
        for (int i = 0; i < 3; i++) push_byte(exp[i]);
        enable = 1'b1;
        for (int i = 0; i < 3 * PERIOD + 100 && rx_q.size() < 3; i++) sample();
        total++;
        if (rx_q.size() != 3) begin
            bad++; $display("FAIL queue_timeout got=%0d exp=3", rx_q.size());
            return;
        end
        repeat (300) sample();
        sent_model += 3;
        total++;
        if (rd_en_log.size() != 3) begin
            bad++; $display("FAIL queue_rd_en_count got=%0d exp=3", rd_en_log.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (rd_en_log[i] - rd_en_log[i-1] != PERIOD)
                    begin bad++; $display("FAIL queue_spacing got=%0d exp=%0d", rd_en_log[i] - rd_en_log[i-1], PERIOD); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rx_q[i] !== exp[i]) begin bad++; $display("FAIL queue_byte%0d got=%h exp=%h", i, rx_q[i], exp[i]); end
        end
        total++;
        if (sent_count !== 16'(sent_model)) begin bad++; $display("FAIL queue_count got=%0d exp=%0d", sent_count, sent_model); end
        total++;
        if (mon_ferr != ferr0) begin bad++; $display("FAIL queue_framing got=%0d exp=%0d", mon_ferr, ferr0); end
    endtask

    task automatic test_back_to_back();
        run_queue(8'h00, 8'hFF, 8'h55);
    endtask

    task automatic test_random_burst();
        run_queue(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_enable_drop();
        logic [7:0] b[3];
        int c;
        int k;
        int ferr0;
        ferr0 = mon_ferr;
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        clear_logs();
        step();
        for (int i = 0; i < 3; i++) push_byte(b[i]);
        enable = 1'b1;
        for (int i = 0; i < 5 && rd_en_log.size() == 0; i++) sample();
        total++;
        if (rd_en_log.size() == 0) begin
            bad++; $display("FAIL endrop_rd_en got=none exp=pulse");
            return;
        end
        c = rd_en_log[0];
        while (cyc < c + 4 * CPB + 50) sample();
        step();
        enable = 1'b0;
        for (int i = 0; i < PERIOD && rx_q.size() < 1; i++) sample();
        repeat (600) sample();
        sent_model += 1;
        total++;
        if (rd_en_log.size() != 1) begin bad++; $display("FAIL endrop_held_rd_en got=%0d exp=1", rd_en_log.size()); end
        total++;
        if (busy !== 1'b0 || serial_tx !== 1'b1)
            begin bad++; $display("FAIL endrop_idle got busy=%b tx=%b exp busy=0 tx=1", busy, serial_tx); end
        total++;
        if (rx_q.size() < 1 || rx_q[0] !== b[0]) begin bad++; $display("FAIL endrop_byte0 got_n=%0d exp=%h", rx_q.size(), b[0]); end
        total++;
        if (sent_count !== 16'(sent_model)) begin bad++; $display("FAIL endrop_count got=%0d exp=%0d", sent_count, sent_model); end
        step();
        k = cyc;
        enable = 1'b1;
        for (int i = 0; i < 2 * PERIOD + 100 && rx_q.size() < 3; i++) sample();
        repeat (300) sample();
        sent_model += 2;
        total++;
        if (rd_en_log.size() != 3 || rd_en_log[1] != k + 1)
            begin bad++; $display("FAIL endrop_resume_rd_en got_n=%0d exp pulse at %0d", rd_en_log.size(), k + 1); end
        total++;
        if (start_log.size() < 2 || start_log[1] != k + 1)
            begin bad++; $display("FAIL endrop_resume_start got_n=%0d exp start at %0d", start_log.size(), k + 1); end
        total++;
        if (rx_q.size() != 3 || rx_q[1] !== b[1] || rx_q[2] !== b[2])
            begin bad++; $display("FAIL endrop_bytes got_n=%0d exp %h %h", rx_q.size(), b[1], b[2]); end
        total++;
        if (sent_count !== 16'(sent_model)) begin bad++; $display("FAIL endrop_final_count got=%0d exp=%0d", sent_count, sent_model); end
        total++;
        if (mon_ferr != ferr0) begin bad++; $display("FAIL endrop_framing got=%0d exp=%0d", mon_ferr, ferr0); end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b0;
        logic [7:0] b1;
        int c;
        int ferr0;
        ferr0 = mon_ferr;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        clear_logs();
        step();
        push_byte(b0);
        push_byte(b1);
        enable = 1'b1;
        for (int i = 0; i < 5 && rd_en_log.size() == 0; i++) sample();
        total++;
        if (rd_en_log.size() == 0) begin
            bad++; $display("FAIL rstmid_rd_en got=none exp=pulse");
            return;
        end
        c = rd_en_log[0];
        while (cyc < c + 6 * CPB + 100) sample();
        @(posedge clk);
        #3;
        rst = 1'b1;
        sent_model = 0;
        #1;
        total++;
        if (serial_tx !== 1'b1) begin bad++; $display("FAIL rstmid_async_tx got=%b exp=1", serial_tx); end
        total++;
        if (sent_count !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", sent_count); end
        repeat (4) sample();
        clear_logs();
        step();
        rst = 1'b0;
        for (int i = 0; i < PERIOD + 50 && rx_q.size() < 1; i++) sample();
        repeat (300) sample();
        sent_model = 1;
        total++;
        if (rd_en_log.size() != 1) begin bad++; $display("FAIL rstmid_rd_en_count got=%0d exp=1", rd_en_log.size()); end
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== b1) begin bad++; $display("FAIL rstmid_byte got_n=%0d exp=%h", rx_q.size(), b1); end
        total++;
        if (mon_ferr != ferr0) begin bad++; $display("FAIL rstmid_framing got=%0d exp=%0d", mon_ferr, ferr0); end
        total++;
        if (sent_count !== 16'(sent_model)) begin bad++; $display("FAIL rstmid_final_count got=%0d exp=%0d", sent_count, sent_model); end
        enable = 1'b0;
    endtask

    // 16 Hz / 4 baud with two stop bits: 44-cycle frames, 4-bit counter wraps after 16.
    task automatic test_wrap();
        int done;
        int run;
        int first_len;
        logic prev_busy;
        done      = 0;
        run       = 0;
        first_len = -1;
        prev_busy = 1'b0;
        rdd_s = 8'($urandom);
        rdv_s = 1'b1;
        en_s  = 1'b1;
        step();
        rst_s = 1'b0;
        for (int i = 0; i < 17 * 45 + 60 && done < 17; i++) begin
            sample();
            if (busy_s) run++;
            if (prev_busy && !busy_s) begin
                done++;
                if (first_len < 0) first_len = run;
                run = 0;
                if (done == 16) begin
                    total++;
                    if (cnt_s !== 4'd0) begin bad++; $display("FAIL wrap_at16 got=%0d exp=0", cnt_s); end
                end
                if (done == 17) begin
                    total++;
                    if (cnt_s !== 4'd1) begin bad++; $display("FAIL wrap_at17 got=%0d exp=1", cnt_s); end
                end
            end
            prev_busy = busy_s;
        end
        total++;
        if (done != 17) begin bad++; $display("FAIL wrap_frames got=%0d exp=17", done); end
        total++;
        if (first_len != 44) begin bad++; $display("FAIL wrap_frame_len got=%0d exp=44", first_len); end
        en_s = 1'b0;
    endtask

    initial begin
        #1;
        rst   = 1'b1;
        rst_s = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_random_burst();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
